serial_loader: RTL and testbench

SERIAL_LOADER -- requirements
Module: serial_loader

---
 rtl/serial_loader_if.sv | 13 +
 rtl/serial_loader.sv | 87 ++++++++
 tb/tb_serial_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/serial_loader_if.sv
// serial_loader_if: control, serial-bit and load-strobe signals of serial_loader
interface serial_loader_if #(parameter int WIDTH = 18);
  logic start;
  logic abort;
  logic bit_in;
  logic bit_valid;
  logic ld;
  logic [WIDTH-1:0] data_out;
  logic busy;
  logic perr;
  modport master(output start, abort, bit_in, bit_valid, input ld, data_out, busy, perr);
  modport slave(input start, abort, bit_in, bit_valid, output ld, data_out, busy, perr);
endinterface

// File: rtl/serial_loader.sv
// serial_loader: MSB-first serial-to-parallel word assembler with a one-cycle load strobe.
// Optional even-parity check after the data bits is enabled by SERIAL_LOADER_PARITY_EN.
module serial_loader #(parameter int WIDTH = 18) (
  input logic clk,
  input logic rst,
  serial_loader_if.slave bus
);
`ifdef SERIAL_LOADER_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n;
`ifdef SERIAL_LOADER_PARITY_EN
  logic par, par_n, perr_r, perr_n;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
`ifdef SERIAL_LOADER_PARITY_EN
      par <= 1'b0;
      perr_r <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
`ifdef SERIAL_LOADER_PARITY_EN
      par <= par_n;
      perr_r <= perr_n;
`endif
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
`ifdef SERIAL_LOADER_PARITY_EN
    par_n = par;
    perr_n = 1'b0;
`endif
    unique case (state)
      IDLE: if (bus.start) begin
        state_n = SHIFT;
        cnt_n = '0;
        sr_n = '0;
`ifdef SERIAL_LOADER_PARITY_EN
        par_n = 1'b0;
`endif
      end
      SHIFT: if (bus.abort) begin
        state_n = IDLE;
        cnt_n = '0;
      end else if (bus.bit_valid) begin
        cnt_n = cnt + 1'b1;
`ifdef SERIAL_LOADER_PARITY_EN
        // the trailing parity bit is checked but never shifted into the word
        if (cnt < CW'(WIDTH)) sr_n = {sr[WIDTH-2:0], bus.bit_in};
        par_n = par ^ bus.bit_in;
        if (cnt == CW'(NB - 1)) begin
          state_n = (par ^ bus.bit_in) ? IDLE : LOAD;
          perr_n = par ^ bus.bit_in;
        end
`else
        sr_n = {sr[WIDTH-2:0], bus.bit_in};
        if (cnt == CW'(NB - 1)) state_n = LOAD;
`endif
      end
      LOAD: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.ld = state == LOAD;
  assign bus.busy = state != IDLE;
  assign bus.data_out = sr;
`ifdef SERIAL_LOADER_PARITY_EN
  assign bus.perr = perr_r;
`else
  assign bus.perr = 1'b0;
`endif
endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader: randomized words with gaps/aborts/resets, scoreboarded load and parity strobes
module tb_serial_loader;
  localparam int W = 18;
`ifdef SERIAL_LOADER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  typedef struct {
    bit is_perr;
    logic [W-1:0] data;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] hold;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  serial_loader_if #(.WIDTH(W)) bus();
  serial_loader #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.ld || bus.perr) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe ld=%0b perr=%0b data=%0h at cycle %0d", bus.ld, bus.perr, bus.data_out, cyc);
      end else begin
        e = q.pop_front();
        chk("strobe_perr", 32'(bus.perr), 32'(e.is_perr));
        chk("strobe_ld", 32'(bus.ld), 32'(!e.is_perr));
        chk("strobe_data", 32'(bus.data_out), 32'(e.data));
        chk("strobe_cycle", cyc, e.cyc);
      end
    end
  end
  // w: word; abort_at/rst_at: bit index where abort/rst interrupts (-1 none);
  // gap_at/gap_len: idle bit_valid cycles before that bit; rnd: random gaps and ignored starts
  task automatic run_word(input logic [W-1:0] w, input int abort_at, input int rst_at,
                          input int gap_at, input int gap_len, input bit bad_par, input bit rnd);
    int nb = W + PAR;
    int gaps = 0;
    int t0;
    exp_t e;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.bit_valid = 1'($urandom);
    bus.bit_in = 1'($urandom);
    step;
    t0 = cyc;
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 1);
    for (int i = 0; i < nb; i++) begin
      int g = (i == gap_at) ? gap_len : (rnd && $urandom_range(3) == 0) ? 1 + $urandom_range(1) : 0;
      repeat (g) begin
        bus.bit_valid = 1'b0;
        bus.bit_in = 1'($urandom);
        bus.start = 1'($urandom);
        step;
        gaps++;
      end
      if (i == abort_at) begin
        bus.abort = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'($urandom);
        bus.start = 1'b0;
        step;
        bus.abort = 1'b0;
        bus.bit_valid = 1'b0;
        hold = (i == 0) ? '0 : W'(w >> (W - ((i > W) ? W : i)));
        chk("busy_after_abort", 32'(bus.busy), 0);
        chk("data_after_abort", 32'(bus.data_out), 32'(hold));
        return;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        bus.bit_valid = 1'b1;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        step;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.bit_valid = 1'b0;
        hold = '0;
        chk("data_after_rst", 32'(bus.data_out), 0);
        chk("busy_after_rst", 32'(bus.busy), 0);
        return;
      end
      bus.bit_in = (i < W) ? w[W-1-i] : (^w) ^ bad_par;
      bus.bit_valid = 1'b1;
      bus.start = 1'($urandom);
      step;
    end
    bus.bit_valid = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'($urandom);
    e.is_perr = (PAR == 1) && bad_par;
    e.data = w;
    e.cyc = t0 + nb + gaps;
    q.push_back(e);
    hold = w;
    chk("busy_after_last_bit", 32'(bus.busy), 32'(!e.is_perr));
    if (!e.is_perr) step;
    bus.abort = 1'b0;
    chk("busy_after_word", 32'(bus.busy), 0);
    chk("data_after_word", 32'(bus.data_out), 32'(hold));
    repeat ($urandom_range(2)) begin
      bus.bit_valid = 1'($urandom);
      bus.bit_in = 1'($urandom);
      bus.abort = 1'($urandom);
      step;
      chk("data_hold_idle", 32'(bus.data_out), 32'(hold));
    end
    bus.abort = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;
    hold = '0;
    repeat (2) step;
    chk("reset_ld", 32'(bus.ld), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_data", 32'(bus.data_out), 0);
    chk("reset_perr", 32'(bus.perr), 0);
    rst = 1'b0;
    step;
    run_word(18'h2D5A3, -1, -1, -1, 0, 1'b0, 1'b0);
    run_word(18'h2D5A3, -1, -1, 8, 3, 1'b0, 1'b0);
    run_word(18'h2D5A3, 10, -1, -1, 0, 1'b0, 1'b0);
    run_word(18'h3FFFF, -1, -1, -1, 0, 1'b0, 1'b0);
    run_word(18'h2D5A3, -1, 12, -1, 0, 1'b0, 1'b0);
    run_word(18'h00001, -1, -1, -1, 0, 1'b0, 1'b1);
`ifdef SERIAL_LOADER_PARITY_EN
    run_word(18'h00003, -1, -1, -1, 0, 1'b0, 1'b0);
    run_word(18'h00003, -1, -1, -1, 0, 1'b1, 1'b0);
`endif
    repeat (40) begin
      run_word(W'($urandom),
               ($urandom_range(4) == 0) ? int'($urandom_range(W + PAR - 1)) : -1,
               ($urandom_range(7) == 0) ? int'($urandom_range(W - 1)) : -1,
               -1, 0, (PAR == 1) && ($urandom_range(2) == 0), 1'b1);
    end
    repeat (3) step;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
